// File: rtl/tty_pkg.sv
// Shared definitions for the VGA text-terminal feeder: control characters
// and the strobe FSM state encoding.
package tty_pkg;

   localparam logic [7:0] TTY_CR  = 8'h0D;
   localparam logic [7:0] TTY_LF  = 8'h0A;
   localparam logic [7:0] TTY_BS  = 8'h08;
   localparam logic [7:0] TTY_ESC = 8'h1B;

   typedef enum logic [1:0] {
      TTY_IDLE = 2'd0,
      TTY_HOLD = 2'd1,
      TTY_GAP  = 2'd2
   } tty_feed_state_t;

endpackage

// File: rtl/tty_fifo.sv
// Synchronous DEPTH x 8 character FIFO with registered full/empty/level
// and asynchronous active-low clear of the control state.
module tty_fifo #(
   parameter int DEPTH = 16,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_50mhz,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [7:0]    i_data,
   input  logic          i_pop,
   output logic [7:0]    o_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [LW-1:0] o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [LW-1:0] r_level;
   logic          r_full;
   logic          r_empty;
   logic [LW-1:0] w_level_nxt;
   logic          w_push;
   logic          w_pop;

   // Qualify against the registered flags so a full FIFO rejects a push
   // even when a pop happens in the same cycle.
   assign w_push = i_push && !r_full;
   assign w_pop  = i_pop && !r_empty;

   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + LW'(1);
      end else if (w_pop && !w_push) begin
         w_level_nxt = r_level - LW'(1);
      end
   end

   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == LW'(DEPTH));
         r_empty <= (w_level_nxt == '0);
      end
   end

   always_ff @(posedge clk_50mhz) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

   assign o_data  = r_mem[r_rptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;
   assign o_level = r_level;

endmodule

// File: rtl/tty_feeder.sv
// Buffered character source driving the VGA terminal BUS/Memwrite strobe.
// Optional TTY_FEEDER_LF2CR_EN: translate LF (0x0A) to CR (0x0D) at pop time.
module tty_feeder
   import tty_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                         clk_50mhz,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [7:0]                   wr_data,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         ovf,
   input  logic                         ovf_clr,
   output logic [31:0]                  BUS,
   output logic                         Memwrite
);

   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

   tty_feed_state_t r_state;
   logic [CW-1:0]   r_cnt;
   logic [7:0]      r_char;
   logic            r_mw;
   logic            r_ovf;
   logic [7:0]      w_fifo_data;
   logic            w_empty;
   logic            w_pop;

   function automatic logic [7:0] lf_xlate(input logic [7:0] c);
`ifdef TTY_FEEDER_LF2CR_EN
      return (c == TTY_LF) ? TTY_CR : c;
`else
      return c;
`endif
   endfunction

   tty_fifo #(
      .DEPTH (DEPTH),
      .LW    ($clog2(DEPTH + 1))
   ) u_fifo (
      .clk_50mhz (clk_50mhz),
      .rst_n     (rst_n),
      .i_push    (wr_en),
      .i_data    (wr_data),
      .i_pop     (w_pop),
      .o_data    (w_fifo_data),
      .o_full    (full),
      .o_empty   (w_empty),
      .o_level   (level)
   );

   // A character is taken from IDLE, or in the last GAP clock so the
   // back-to-back pitch is exactly HOLD_CYCLES + GAP_CYCLES.
   assign w_pop = !w_empty &&
                  ((r_state == TTY_IDLE) || ((r_state == TTY_GAP) && (r_cnt == '0)));

   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= TTY_IDLE;
         r_cnt   <= '0;
         r_char  <= '0;
         r_mw    <= 1'b0;
      end else if (w_pop) begin
         r_state <= TTY_HOLD;
         r_cnt   <= HOLD_LD;
         r_char  <= lf_xlate(w_fifo_data);
         r_mw    <= 1'b1;
      end else begin
         case (r_state)
            TTY_HOLD: begin
               if (r_cnt == '0) begin
                  r_state <= TTY_GAP;
                  r_cnt   <= GAP_LD;
                  r_mw    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            TTY_GAP: begin
               if (r_cnt == '0) begin
                  r_state <= TTY_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: begin
               r_state <= TTY_IDLE;
            end
         endcase
      end
   end

   // A set in the same cycle as a clear wins, so no overflow is lost.
   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (wr_en && full) begin
         r_ovf <= 1'b1;
      end else if (ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

   assign ovf      = r_ovf;
   assign BUS      = {24'h000000, r_char};
   assign Memwrite = r_mw;

endmodule

// File: tb/tb_tty_feeder.sv
// Scoreboard bench for tty_feeder: stimulus queues expected characters,
// a forked monitor checks every Memwrite pulse (data, hold and gap length).
module tb_tty_feeder;

   localparam int DEPTH = 16;
   localparam int HOLD  = 4;
   localparam int GAP   = 4;

   logic        clk_50mhz = 1'b0;
   logic        rst_n     = 1'b0;
   logic        wr_en     = 1'b0;
   logic [7:0]  wr_data   = 8'h00;
   logic        ovf_clr   = 1'b0;
   logic        full;
   logic [4:0]  level;
   logic        ovf;
   logic [31:0] BUS;
   logic        Memwrite;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  exp_q[$];

   always #10 clk_50mhz = ~clk_50mhz;

   tty_feeder #(
      .DEPTH       (DEPTH),
      .HOLD_CYCLES (HOLD),
      .GAP_CYCLES  (GAP)
   ) dut (
      .clk_50mhz (clk_50mhz),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .level     (level),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr),
      .BUS       (BUS),
      .Memwrite  (Memwrite)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] term_char(input logic [7:0] c);
`ifdef TTY_FEEDER_LF2CR_EN
      return (c == 8'h0A) ? 8'h0D : c;
`else
      return c;
`endif
   endfunction

   task automatic monitor();
      logic       prev = 1'b0;
      int         hi   = 0;
      int         lo   = 1000;
      logic [7:0] e;
      forever begin
         @(negedge clk_50mhz);
         if (!rst_n) begin
            prev = 1'b0;
            hi   = 0;
            lo   = 1000;
         end else begin
            if (Memwrite && !prev) begin
               chk("gap_at_least_min", 32'(lo >= GAP), 32'd1);
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_strobe: BUS=0x%0h with no character pending at %0t", BUS, $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("bus_char", BUS, {24'h000000, e});
               end
               hi = 1;
            end else if (Memwrite) begin
               hi++;
            end else if (prev) begin
               chk("hold_len", 32'(hi), 32'(HOLD));
               lo = 1;
            end else begin
               lo++;
            end
            prev = Memwrite;
         end
      end
   endtask

   task automatic push1(input logic [7:0] b);
      @(negedge clk_50mhz);
      wr_en   = 1'b1;
      wr_data = b;
      exp_q.push_back(term_char(b));
   endtask

   initial begin
      int hi_cnt;
      fork
         monitor();
      join_none

      // Reset state
      repeat (2) @(negedge clk_50mhz);
      chk("rst_bus", BUS, 32'h0);
      chk("rst_memwrite", 32'(Memwrite), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk_50mhz);

      // Single character latency
      push1(8'h41);
      @(negedge clk_50mhz);
      wr_en = 1'b0;
      chk("single_level_c1", 32'(level), 32'd1);
      chk("single_mw_c1", 32'(Memwrite), 32'd0);
      @(negedge clk_50mhz);
      chk("single_mw_c2", 32'(Memwrite), 32'd1);
      chk("single_bus_c2", BUS, 32'h00000041);
      chk("single_level_c2", 32'(level), 32'd0);
      repeat (12) @(negedge clk_50mhz);
      chk("single_idle_mw", 32'(Memwrite), 32'd0);
      chk("single_bus_kept", BUS, 32'h00000041);

      // Burst of three
      push1(8'h48);
      push1(8'h49);
      push1(8'h0D);
      @(negedge clk_50mhz);
      wr_en = 1'b0;
      repeat (30) @(negedge clk_50mhz);
      chk("burst_level", 32'(level), 32'd0);
      chk("burst_drained", 32'(exp_q.size()), 32'd0);

      // Line feed
      push1(8'h0A);
      @(negedge clk_50mhz);
      wr_en = 1'b0;
      repeat (12) @(negedge clk_50mhz);
      chk("lf_drained", 32'(exp_q.size()), 32'd0);

      // Overflow: with pops at cycles 1, 9, 17 the FIFO fills at cycle 19
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_50mhz);
         if (i == 18) chk("ovf_not_full_c18", 32'(full), 32'd0);
         if (i == 19) begin
            chk("ovf_full_c19", 32'(full), 32'd1);
            chk("ovf_clear_c19", 32'(ovf), 32'd0);
         end
         wr_en   = 1'b1;
         wr_data = 8'(8'h60 + i);
         if (i < 19) exp_q.push_back(term_char(8'(8'h60 + i)));
      end
      @(negedge clk_50mhz);
      wr_en = 1'b0;
      chk("ovf_set", 32'(ovf), 32'd1);
      chk("ovf_level_full", 32'(level), 32'd16);
      ovf_clr = 1'b1;
      @(negedge clk_50mhz);
      chk("ovf_cleared", 32'(ovf), 32'd0);
      wr_en   = 1'b1;
      wr_data = 8'h7F;
      @(negedge clk_50mhz);
      wr_en = 1'b0;
      chk("ovf_set_beats_clr", 32'(ovf), 32'd1);
      @(negedge clk_50mhz);
      ovf_clr = 1'b0;
      chk("ovf_cleared_again", 32'(ovf), 32'd0);
      repeat (180) @(negedge clk_50mhz);
      chk("ovf_drain_level", 32'(level), 32'd0);
      chk("ovf_drain_full", 32'(full), 32'd0);
      chk("ovf_drained", 32'(exp_q.size()), 32'd0);

      // Reset during the second HOLD clock
      push1(8'h55);
      @(negedge clk_50mhz);
      wr_en = 1'b0;
      @(negedge clk_50mhz);
      @(negedge clk_50mhz);
      rst_n = 1'b0;
      #1;
      chk("midrst_memwrite", 32'(Memwrite), 32'd0);
      chk("midrst_bus", BUS, 32'h0);
      chk("midrst_level", 32'(level), 32'd0);
      @(negedge clk_50mhz);
      rst_n = 1'b1;
      hi_cnt = 0;
      repeat (12) begin
         @(negedge clk_50mhz);
         if (Memwrite) hi_cnt++;
      end
      chk("midrst_stays_idle", 32'(hi_cnt), 32'd0);
      chk("midrst_level_after", 32'(level), 32'd0);

      // Recovery after reset
      push1(8'h5A);
      @(negedge clk_50mhz);
      wr_en = 1'b0;
      repeat (12) @(negedge clk_50mhz);
      chk("final_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
